// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Covers opcodes, FSM state codes, mux-select codes and the decoded control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQEX  = 4'd8,
        S_IEXE   = 4'd9,
        S_IWB    = 4'd10,
        S_JEX    = 4'd11
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       iord;
        logic       mem_write;
        logic       reg_write;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] alu_op;
        logic [1:0] pcsrc;
        logic       ext_zero;
        logic       illegal;
    } ctrl_t;

    // andi/ori take a zero-extended immediate; everything else sign-extends.
    function automatic logic op_is_zext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_J: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state/opcode to control-word decoder, zero latency.
// Only pc_en/ir_write look at mem_ready/zero, so selects stay steady across stalls.
module mc_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o          = '0;
        ctrl_o.ext_zero = op_is_zext(op_i);
        case (state_i)
            S_FETCH: begin
                ctrl_o.alusrcb  = SRCB_FOUR;
                ctrl_o.alu_op   = ALU_ADD;
                ctrl_o.ir_write = mem_ready_i;
                ctrl_o.pc_en    = mem_ready_i;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                ctrl_o.alusrcb = SRCB_IMM_SH2;
                ctrl_o.alu_op  = ALU_ADD;
                ctrl_o.illegal = !op_is_legal(op_i);
            end
            S_MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.alu_op  = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl_o.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.memtoreg  = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_RTEXE: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_RT;
                ctrl_o.alu_op  = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.regdst    = 1'b1;
            end
            S_BEQEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_RT;
                ctrl_o.alu_op  = ALU_SUB;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
                ctrl_o.pc_en   = zero_i;
            end
            S_IEXE: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.alu_op  = op_is_zext(op_i) ? ALU_LOGIC : ALU_ADD;
            end
            S_IWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_JEX: begin
                ctrl_o.pcsrc = PCSRC_JUMP;
                ctrl_o.pc_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control FSM; one state per cycle, outputs combinational from state.
// FETCH/MEMRD/MEMWR hold while mem_ready is low; all strobes and selects read 0 during reset.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_write,
    output logic       reg_write,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] alu_op,
    output logic [1:0] pcsrc,
    output logic       ext_zero,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q, state_d;
    ctrl_t  dec_ctrl;
    ctrl_t  out_ctrl;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_RTYPE:                 state_d = S_RTEXE;
                    OP_BEQ:                   state_d = S_BEQEX;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXE;
                    OP_J:                     state_d = S_JEX;
                    default:                  state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_RTEXE:  state_d = S_ALUWB;
            S_IEXE:   state_d = S_IWB;
            S_MEMWB, S_ALUWB, S_BEQEX,
            S_IWB, S_JEX: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state_i     (state_q),
        .op_i        (op),
        .mem_ready_i (mem_ready),
        .zero_i      (zero),
        .ctrl_o      (dec_ctrl)
    );

    // Gating on rst keeps an abandoned instruction from writing anything.
    assign out_ctrl = rst ? dec_ctrl : '0;

    assign pc_en     = out_ctrl.pc_en;
    assign ir_write  = out_ctrl.ir_write;
    assign iord      = out_ctrl.iord;
    assign mem_write = out_ctrl.mem_write;
    assign reg_write = out_ctrl.reg_write;
    assign regdst    = out_ctrl.regdst;
    assign memtoreg  = out_ctrl.memtoreg;
    assign alusrca   = out_ctrl.alusrca;
    assign alusrcb   = out_ctrl.alusrcb;
    assign alu_op    = out_ctrl.alu_op;
    assign pcsrc     = out_ctrl.pcsrc;
    assign ext_zero  = out_ctrl.ext_zero;
    assign illegal   = out_ctrl.illegal;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction step table model, directed plan cases, then random traffic.
module tb_multicycle_ctrl;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, JMP = 6'b000010;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       iord;
        logic       mem_write;
        logic       reg_write;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] alu_op;
        logic [1:0] pcsrc;
        logic       ext_zero;
        logic       illegal;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, ir_write, iord, mem_write, reg_write, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, alu_op, pcsrc;
    logic       ext_zero, illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ir_write(ir_write), .iord(iord), .mem_write(mem_write),
        .reg_write(reg_write), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .alu_op(alu_op), .pcsrc(pcsrc), .ext_zero(ext_zero),
        .illegal(illegal), .state(state)
    );

    ctl_t dut_ctl;
    assign dut_ctl = {pc_en, ir_write, iord, mem_write, reg_write, regdst, memtoreg,
                      alusrca, alusrcb, alu_op, pcsrc, ext_zero, illegal};

    int   tests = 0;
    int   fails = 0;
    int   step  = 0;
    ctl_t obs_ctl;
    logic [3:0] obs_state;
    ctl_t tr_ctl [0:47];
    logic [3:0] tr_state [0:47];
    int   tr_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] o);
        return o == LW || o == SW || o == RT || o == BEQ || o == ADDI ||
               o == ANDI || o == ORI || o == JMP;
    endfunction

    // Number of steps each instruction class walks through when memory is always ready.
    function automatic int seq_len(input logic [5:0] o);
        if (o == LW) return 5;
        if (o == SW || o == RT || o == ADDI || o == ANDI || o == ORI) return 4;
        if (o == BEQ || o == JMP) return 3;
        return 2;
    endfunction

    // Debug state code visited at step i of instruction o.
    function automatic int seq_at(input logic [5:0] o, input int i);
        if (i <= 1) return i;
        if (o == LW) return (i == 2) ? 2 : (i == 3) ? 3 : 4;
        if (o == SW) return (i == 2) ? 2 : 5;
        if (o == RT) return (i == 2) ? 6 : 7;
        if (o == BEQ) return 8;
        if (o == ADDI || o == ANDI || o == ORI) return (i == 2) ? 9 : 10;
        if (o == JMP) return 11;
        return 0;
    endfunction

    function automatic ctl_t model_ctl(input int ph, input logic [5:0] o,
                                       input logic mr, input logic z, input logic r);
        ctl_t c;
        c = '0;
        if (!r) return c;
        c.ext_zero = (o == ANDI || o == ORI);
        case (ph)
            0:  begin c.alusrcb = 2'b01; c.ir_write = mr; c.pc_en = mr; end
            1:  begin c.alusrcb = 2'b11; c.illegal = !is_legal(o); end
            2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            3:  c.iord = 1'b1;
            4:  begin c.reg_write = 1'b1; c.memtoreg = 1'b1; end
            5:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
            6:  begin c.alusrca = 1'b1; c.alu_op = 2'b10; end
            7:  begin c.reg_write = 1'b1; c.regdst = 1'b1; end
            8:  begin c.alusrca = 1'b1; c.alu_op = 2'b01; c.pcsrc = 2'b01; c.pc_en = z; end
            9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alu_op = c.ext_zero ? 2'b11 : 2'b00; end
            10: c.reg_write = 1'b1;
            11: begin c.pcsrc = 2'b10; c.pc_en = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    // One clock: drive, compare against the model, then advance the model across the edge.
    task automatic tick(input logic [5:0] o, input logic mr, input logic z, input logic r);
        int ph;
        @(posedge clk);
        #1;
        op = o; mem_ready = mr; zero = z; rst = r;
        @(negedge clk);
        ph = seq_at(o, step);
        chk("state", 32'(state), 32'(ph));
        chk("ctrl", 32'(dut_ctl), 32'(model_ctl(ph, o, mr, z, r)));
        obs_ctl = dut_ctl;
        obs_state = state;
        if (!r) begin
            step = 0;
        end else if (!((ph == 0 || ph == 3 || ph == 5) && !mr)) begin
            step++;
            if (step >= seq_len(o)) step = 0;
        end
    endtask

    // Runs one instruction from FETCH, holding mem_ready low for `stalls` cycles in its memory wait.
    task automatic run_instr(input logic [5:0] o, input int stalls, input logic z);
        int left;
        int ph;
        logic mr;
        left = stalls;
        tr_len = 0;
        do begin
            ph = seq_at(o, step);
            mr = ((ph == 3 || ph == 5) && left > 0) ? 1'b0 : 1'b1;
            if (!mr) left--;
            tick(o, mr, z, 1'b1);
            tr_ctl[tr_len] = obs_ctl;
            tr_state[tr_len] = obs_state;
            tr_len++;
        end while (step != 0 && tr_len < 48);
        if (tr_len >= 48) chk("instr_timeout", 32'(tr_len), 32'd0);
    endtask

    function automatic int count_where(input int which);
        int n;
        n = 0;
        for (int i = 0; i < tr_len; i++) begin
            case (which)
                0: n += int'(tr_ctl[i].pc_en);
                1: n += int'(tr_ctl[i].reg_write);
                2: n += int'(tr_ctl[i].mem_write);
                3: n += int'(tr_ctl[i].mem_write && tr_ctl[i].iord);
                4: n += int'(tr_ctl[i].illegal);
                default: ;
            endcase
        end
        return n;
    endfunction

    initial begin
        logic [5:0] rop;
        logic [5:0] optab [0:7];
        optab = '{LW, SW, RT, BEQ, ADDI, ANDI, ORI, JMP};

        // Reset: state FETCH, every output 0.
        tick(6'd0, 1'b1, 1'b1, 1'b0);
        tick(6'd0, 1'b1, 1'b1, 1'b0);
        chk("reset_state", 32'(obs_state), 32'd0);
        chk("reset_ctrl", 32'(obs_ctl), 32'd0);

        run_instr(LW, 0, 1'b0);
        chk("lw_cycles", 32'(tr_len), 32'd5);
        chk("lw_states", {12'd0, tr_state[0], tr_state[1], tr_state[2], tr_state[3], tr_state[4]}, 32'h01234);
        chk("lw_writes", 32'(count_where(1)), 32'd1);
        chk("lw_wb_memtoreg", {31'd0, tr_ctl[4].reg_write && tr_ctl[4].memtoreg}, 32'd1);
        chk("lw_next_fetch", 32'(step), 32'd0);

        run_instr(SW, 3, 1'b0);
        chk("sw_cycles", 32'(tr_len), 32'd7);
        chk("sw_memwrite", 32'(count_where(2)), 32'd4);
        chk("sw_memwrite_iord", 32'(count_where(3)), 32'd4);

        run_instr(BEQ, 0, 1'b1);
        chk("beq_taken_cycles", 32'(tr_len), 32'd3);
        chk("beq_taken_pcsel", {29'd0, tr_ctl[2].pc_en, tr_ctl[2].pcsrc}, 32'h5);
        run_instr(BEQ, 0, 1'b0);
        chk("beq_nt_cycles", 32'(tr_len), 32'd3);
        chk("beq_nt_pc_en", {31'd0, tr_ctl[2].pc_en}, 32'd0);

        run_instr(ORI, 0, 1'b0);
        chk("ori_iexe", {29'd0, tr_ctl[2].ext_zero, tr_ctl[2].alu_op}, 32'h7);
        chk("ori_wb", {30'd0, tr_ctl[3].reg_write, tr_ctl[3].regdst}, 32'h2);
        run_instr(ADDI, 0, 1'b0);
        chk("addi_iexe", {29'd0, tr_ctl[2].ext_zero, tr_ctl[2].alu_op}, 32'h0);
        chk("addi_wb", {30'd0, tr_ctl[3].reg_write, tr_ctl[3].regdst}, 32'h2);

        run_instr(6'b111111, 0, 1'b0);
        chk("ill_cycles", 32'(tr_len), 32'd2);
        chk("ill_pulse", 32'(count_where(4)), 32'd1);
        chk("ill_pulse_decode", {31'd0, tr_ctl[1].illegal}, 32'd1);
        chk("ill_no_writes", 32'(count_where(1) + count_where(2)), 32'd0);

        // Reset asserted while lw sits in MEMWB.
        for (int i = 0; i < 4; i++) tick(LW, 1'b1, 1'b0, 1'b1);
        tick(LW, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_state", 32'(obs_state), 32'd4);
        chk("rst_mid_no_write", {31'd0, obs_ctl.reg_write}, 32'd0);
        tick(LW, 1'b1, 1'b0, 1'b1);
        chk("rst_mid_fetch", 32'(obs_state), 32'd0);

        rop = LW;
        for (int n = 0; n < 3000; n++) begin
            if (step == 0) begin
                if ($urandom_range(0, 9) < 8) rop = optab[$urandom_range(0, 7)];
                else rop = 6'($urandom);
            end
            tick(rop, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 80) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
